cnt_cmp_evt: RTL and testbench

Compare/event stage directly downstream of the 16-bit free-running counter cell. Watches the counter value, detects a programmable low mark followed by a high mark, emits single-cycle event pulses, and returns a one-cycle clear request that drives the counter's clear condition input. Supports one-shot and periodic arming and keeps a saturating completion count.

---
 rtl/cnt_cmp_evt_if.sv | 30 +++
 rtl/cnt_cmp_evt.sv | 147 ++++++++++++++
 tb/tb_cnt_cmp_evt.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_cmp_evt_if.sv
// Counter-compare bus: counter sample, arm/disarm controls, latched marks and event outputs.
// master drives the counter/control side, slave is the compare/event stage.
interface cnt_cmp_evt_if #(
    parameter int WIDTH  = 16,
    parameter int MCNT_W = 8
);
    logic [WIDTH-1:0]  cnt_in;
    logic              cnt_vld;
    logic              arm;
    logic              disarm;
    logic              mode;
    logic [WIDTH-1:0]  cmp_lo;
    logic [WIDTH-1:0]  cmp_hi;
    logic              busy;
    logic              evt_lo;
    logic              evt_hi;
    logic              clr_req;
    logic [MCNT_W-1:0] match_cnt;
    logic              err_to;

    modport master (
        output cnt_in, cnt_vld, arm, disarm, mode, cmp_lo, cmp_hi,
        input  busy, evt_lo, evt_hi, clr_req, match_cnt, err_to
    );

    modport slave (
        input  cnt_in, cnt_vld, arm, disarm, mode, cmp_lo, cmp_hi,
        output busy, evt_lo, evt_hi, clr_req, match_cnt, err_to
    );
endinterface

// File: rtl/cnt_cmp_evt.sv
// Lo-then-hi mark detector behind the free-running counter; pulses events and requests a counter clear.
// Latency: mark sampled at edge N -> evt_* during N+1, clr_req during N+2; all outputs registered.
// No backpressure: cnt_vld=0 skips compares. Optional LO_SEEN watchdog enabled by CNT_CMP_TIMEOUT_EN.
module cnt_cmp_evt #(
    parameter int WIDTH   = 16,
    parameter int MCNT_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic         mclk,
    input  logic         mreset,
    cnt_cmp_evt_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        LO_SEEN = 2'd2,
        CLEAR   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  lo_r, hi_r;
    logic              mode_r;
    logic              busy_q, evt_lo_q, evt_hi_q, clr_req_q;
    logic              evt_lo_d, evt_hi_d, clr_req_d, arm_acc;
    logic [MCNT_W-1:0] match_cnt_q;
    logic              lo_hit, hi_hit;

    assign lo_hit = bus.cnt_vld && (bus.cnt_in == lo_r);
    assign hi_hit = bus.cnt_vld && (bus.cnt_in == hi_r);

`ifdef CNT_CMP_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_q;
    logic            wd_exp;
    logic            err_to_d, err_to_q;

    assign wd_exp = (wd_q == WD_W'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d   = state_q;
        evt_lo_d  = 1'b0;
        evt_hi_d  = 1'b0;
        clr_req_d = 1'b0;
        arm_acc   = 1'b0;
`ifdef CNT_CMP_TIMEOUT_EN
        err_to_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // arm beats a simultaneous disarm here, so disarm is simply not looked at
                if (bus.arm) begin
                    arm_acc = 1'b1;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (bus.disarm) begin
                    state_d = IDLE;
                end else if (lo_hit) begin
                    evt_lo_d = 1'b1;
                    if (lo_r == hi_r) begin
                        evt_hi_d = 1'b1;
                        state_d  = CLEAR;
                    end else begin
                        state_d  = LO_SEEN;
                    end
                end
            end
            LO_SEEN: begin
                if (bus.disarm) begin
                    state_d = IDLE;
                end else if (hi_hit) begin
                    evt_hi_d = 1'b1;
                    state_d  = CLEAR;
`ifdef CNT_CMP_TIMEOUT_EN
                end else if (wd_exp) begin
                    err_to_d = 1'b1;
                    state_d  = IDLE;
`endif
                end
            end
            CLEAR: begin
                clr_req_d = 1'b1;
                state_d   = mode_r ? ARMED : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk) begin
        if (mreset) begin
            state_q     <= IDLE;
            lo_r        <= '0;
            hi_r        <= '0;
            mode_r      <= 1'b0;
            busy_q      <= 1'b0;
            evt_lo_q    <= 1'b0;
            evt_hi_q    <= 1'b0;
            clr_req_q   <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != IDLE);
            evt_lo_q  <= evt_lo_d;
            evt_hi_q  <= evt_hi_d;
            clr_req_q <= clr_req_d;
            if (arm_acc) begin
                lo_r   <= bus.cmp_lo;
                hi_r   <= bus.cmp_hi;
                mode_r <= bus.mode;
            end
            // count lands together with clr_req and sticks at all-ones
            if ((state_q == CLEAR) && !(&match_cnt_q))
                match_cnt_q <= match_cnt_q + MCNT_W'(1);
        end
    end

`ifdef CNT_CMP_TIMEOUT_EN
    // held at zero outside LO_SEEN, so every entry starts a fresh window
    always_ff @(posedge mclk) begin
        if (mreset) begin
            wd_q     <= '0;
            err_to_q <= 1'b0;
        end else begin
            err_to_q <= err_to_d;
            if (state_q != LO_SEEN)
                wd_q <= '0;
            else
                wd_q <= wd_q + WD_W'(1);
        end
    end

    assign bus.err_to = err_to_q;
`else
    assign bus.err_to = 1'b0;
`endif

    assign bus.busy      = busy_q;
    assign bus.evt_lo    = evt_lo_q;
    assign bus.evt_hi    = evt_hi_q;
    assign bus.clr_req   = clr_req_q;
    assign bus.match_cnt = match_cnt_q;

endmodule

// File: tb/tb_cnt_cmp_evt.sv
// Bench for cnt_cmp_evt: sequence-level reference model checked every cycle plus directed literal checks.
module tb_cnt_cmp_evt;
    localparam int W  = 16;
    localparam int MW = 8;
    localparam int TO = 16;

    logic mclk   = 1'b0;
    logic mreset = 1'b1;
    always #5 mclk = ~mclk;

    cnt_cmp_evt_if #(.WIDTH(W), .MCNT_W(MW)) bus();

    cnt_cmp_evt #(.WIDTH(W), .MCNT_W(MW), .TIMEOUT(TO)) dut (
        .mclk   (mclk),
        .mreset (mreset),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit auto_cnt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: tracks where the sequence is (waiting for lo, waiting for hi, completing).
    bit          m_active = 0, m_lo_done = 0, m_closing = 0, m_per = 0;
    logic [15:0] m_lo = '0, m_hi = '0;
    int          m_done = 0, m_wd = 0;
    bit          e_lo = 0, e_hi = 0, e_clr = 0, e_to = 0, e_busy = 0;
    int          e_cnt = 0;
    logic [15:0] last_cnt = '0;
    int          cyc = 0;

    always @(posedge mclk) begin
        cyc++;
        last_cnt = bus.cnt_in;
        e_lo = 0; e_hi = 0; e_clr = 0; e_to = 0;
        if (mreset) begin
            m_active = 0; m_lo_done = 0; m_closing = 0; m_per = 0;
            m_lo = '0; m_hi = '0; m_done = 0; m_wd = 0;
        end else if (m_closing) begin
            e_clr = 1; m_done++; m_closing = 0; m_lo_done = 0; m_active = m_per;
        end else if (!m_active) begin
            if (bus.arm) begin
                m_active = 1; m_lo = bus.cmp_lo; m_hi = bus.cmp_hi; m_per = bus.mode;
            end
        end else if (bus.disarm) begin
            m_active = 0; m_lo_done = 0;
        end else if (!m_lo_done) begin
            if (bus.cnt_vld && bus.cnt_in == m_lo) begin
                e_lo = 1;
                if (m_lo == m_hi) begin e_hi = 1; m_closing = 1; end
                else begin m_lo_done = 1; m_wd = 0; end
            end
        end else begin
            if (bus.cnt_vld && bus.cnt_in == m_hi) begin
                e_hi = 1; m_closing = 1; m_lo_done = 0;
            end
`ifdef CNT_CMP_TIMEOUT_EN
            else if (m_wd == TO - 1) begin
                e_to = 1; m_active = 0; m_lo_done = 0;
            end else m_wd++;
`endif
        end
        e_busy = m_active || m_closing;
        e_cnt  = (m_done > 255) ? 255 : m_done;
    end

    // per-cycle comparison plus pulse bookkeeping for the directed checks
    int n_lo, n_hi, n_clr, n_to, n_split, lo_at, hi_at, to_at, hi_cyc, clr_cyc;

    always @(negedge mclk) begin
        if (chk_en) begin
            chk("busy",      bus.busy,      e_busy);
            chk("evt_lo",    bus.evt_lo,    e_lo);
            chk("evt_hi",    bus.evt_hi,    e_hi);
            chk("clr_req",   bus.clr_req,   e_clr);
            chk("err_to",    bus.err_to,    e_to);
            chk("match_cnt", bus.match_cnt, e_cnt);
            if (bus.evt_lo === 1'b1) begin n_lo++; lo_at = last_cnt; end
            if (bus.evt_hi === 1'b1) begin n_hi++; hi_at = last_cnt; hi_cyc = cyc; end
            if (bus.clr_req === 1'b1) begin n_clr++; clr_cyc = cyc; end
            if (bus.err_to === 1'b1) begin n_to++; to_at = last_cnt; end
            if (bus.evt_lo !== bus.evt_hi) n_split++;
        end
    end

    task automatic clr_stats();
        n_lo = 0; n_hi = 0; n_clr = 0; n_to = 0; n_split = 0;
        lo_at = -1; hi_at = -1; to_at = -1; hi_cyc = 0; clr_cyc = -100;
    endtask

    // one clock; the modelled counter clears at the edge that sees clr_req
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            logic c;
            @(negedge mclk);
            c = bus.clr_req;
            @(posedge mclk);
            #2;
            bus.arm    = 1'b0;
            bus.disarm = 1'b0;
            if (auto_cnt) bus.cnt_in = c ? 16'd0 : bus.cnt_in + 16'd1;
        end
    endtask

    task automatic do_arm(input logic [15:0] lo, input logic [15:0] hi, input logic md,
                          input logic [15:0] start, input bit dis);
        bus.cmp_lo  = lo;
        bus.cmp_hi  = hi;
        bus.mode    = md;
        bus.arm     = 1'b1;
        bus.disarm  = dis;
        bus.cnt_in  = start;
        bus.cnt_vld = 1'b1;
        auto_cnt    = 1'b0;
        step(1);
        auto_cnt    = 1'b1;
        // inputs move while busy; the latched copies must not
        bus.cmp_lo  = ~lo;
        bus.cmp_hi  = ~hi;
        bus.mode    = ~md;
    endtask

    initial begin
        bus.cnt_in = '0; bus.cnt_vld = 1'b0; bus.arm = 1'b0; bus.disarm = 1'b0;
        bus.mode = 1'b0; bus.cmp_lo = '0; bus.cmp_hi = '0;
        clr_stats();

        // reset state
        mreset = 1'b1;
        step(1);
        chk_en = 1'b1;
        step(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_evt",  {bus.evt_lo, bus.evt_hi, bus.clr_req, bus.err_to}, 0);
        chk("rst_mcnt", bus.match_cnt, 0);
        mreset = 1'b0;
        step(1);

        // one-shot 10 -> 20, arm raised together with disarm
        clr_stats();
        do_arm(16'd10, 16'd20, 1'b0, 16'd0, 1'b1);
        step(50);
        chk("os_nlo",  n_lo, 1);
        chk("os_loat", lo_at, 10);
        chk("os_nhi",  n_hi, 1);
        chk("os_hiat", hi_at, 20);
        chk("os_nclr", n_clr, 1);
        chk("os_clrlat", clr_cyc - hi_cyc, 1);
        chk("os_mcnt", bus.match_cnt, 1);
        chk("os_busy", bus.busy, 0);

        // reset mid-LO_SEEN
        do_arm(16'd10, 16'd20, 1'b0, 16'd0, 1'b0);
        step(14);
        clr_stats();
        mreset = 1'b1;
        step(3);
        chk("mr_busy", bus.busy, 0);
        chk("mr_out",  {bus.evt_lo, bus.evt_hi, bus.clr_req, bus.err_to}, 0);
        chk("mr_mcnt", bus.match_cnt, 0);
        mreset = 1'b0;
        step(3);
        chk("mr_nclr", n_clr, 0);
        chk("mr_busy2", bus.busy, 0);

        // periodic, equal marks, three passes
        clr_stats();
        do_arm(16'd5, 16'd5, 1'b1, 16'd0, 1'b0);
        begin
            int k;
            for (k = 0; k < 100; k++) begin
                step(1);
                if (bus.match_cnt == 8'd3) break;
            end
            if (k == 100) begin tests++; fails++; $display("FAIL per_wait: match_cnt stuck at %0d, expected 3", bus.match_cnt); end
        end
        chk("per_mcnt", bus.match_cnt, 3);
        chk("per_busy", bus.busy, 1);
        bus.disarm = 1'b1;
        step(2);
        chk("per_nclr",  n_clr, 3);
        chk("per_nhi",   n_hi, 3);
        chk("per_split", n_split, 0);
        chk("per_idle",  bus.busy, 0);

        // hi below lo: hi match only after the counter wraps
        clr_stats();
        do_arm(16'd65530, 16'd3, 1'b0, 16'd65525, 1'b0);
        step(20);
        chk("wr_loat", lo_at, 65530);
        chk("wr_nhi",  n_hi, 1);
        chk("wr_hiat", hi_at, 3);
        chk("wr_clrlat", clr_cyc - hi_cyc, 1);
        chk("wr_mcnt", bus.match_cnt, 4);

        // disarm in the same cycle the hi mark is on the counter
        clr_stats();
        do_arm(16'd10, 16'd20, 1'b0, 16'd0, 1'b0);
        begin
            int k;
            for (k = 0; k < 40; k++) begin
                if (bus.cnt_in == 16'd20) break;
                step(1);
            end
            if (k == 40) begin tests++; fails++; $display("FAIL dr_wait: cnt_in %0d, expected 20", bus.cnt_in); end
        end
        bus.disarm = 1'b1;
        step(6);
        chk("dr_nlo",  n_lo, 1);
        chk("dr_nhi",  n_hi, 0);
        chk("dr_nclr", n_clr, 0);
        chk("dr_busy", bus.busy, 0);
        chk("dr_mcnt", bus.match_cnt, 4);

        // saturation: counter parked on the mark, a completion every two cycles
        do_arm(16'd5, 16'd5, 1'b1, 16'd5, 1'b0);
        auto_cnt = 1'b0;
        step(620);
        chk("sat_mcnt", bus.match_cnt, 255);
        bus.cnt_vld = 1'b0;
        step(3);
        bus.disarm = 1'b1;
        step(2);
        chk("sat_busy",  bus.busy, 0);
        chk("sat_mcnt2", bus.match_cnt, 255);

        // lo reached, hi never arrives
        clr_stats();
        do_arm(16'd4, 16'd1000, 1'b0, 16'd0, 1'b0);
        step(40);
`ifdef CNT_CMP_TIMEOUT_EN
        chk("to_nto",  n_to, 1);
        chk("to_at",   to_at, 20);
        chk("to_busy", bus.busy, 0);
        chk("to_nclr", n_clr, 0);
`else
        chk("to_nto",  n_to, 0);
        chk("to_busy", bus.busy, 1);
        bus.disarm = 1'b1;
        step(2);
        chk("to_idle", bus.busy, 0);
`endif
        chk("to_mcnt", bus.match_cnt, 255);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
